ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single `ram_adapter` between the instruction-fetch port (IF stage) and the data port (MEM stage). It latches one request at a time and holds it stable on the adapter interface until the adapter answers. It then returns data and a one-cycle ready pulse to the winning port, and forces the adapter back to idle before the next grant. It sits between the CPU core and `ram_adapter`, and raises a stall request so the pipeline waits while either port is unserved.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles a grant may wait for `ram_ready_i` before it is aborted. Legal range 2–255.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset (`RstEnable`).
- `if_ce_i`  in  1  fetch request, held high until `if_ready_o`.
- `if_addr_i`  in  `RegBus`  fetch address.
- `if_data_o`  out  `RegBus`  fetched word, valid while `if_ready_o`=1.
- `if_ready_o`  out  1  one-cycle completion pulse for the fetch port.
- `mem_ce_i`  in  1  data request, held high until `mem_ready_o`.
- `mem_we_i`  in  1  1 = write, 0 = read.
- `mem_sel_i`  in  4  byte select.
- `mem_addr_i`  in  `RegBus`  data address.
- `mem_data_i`  in  `RegBus`  write data.
- `mem_data_o`  out  `RegBus`  read word, valid while `mem_ready_o`=1.
- `mem_ready_o`  out  1  one-cycle completion pulse for the data port.
- `ram_ce_o`, `ram_we_o`, `ram_sel_o[3:0]`, `ram_addr_o[RegBus]`, `ram_data_o[RegBus]`  out  request signals to the adapter. All are registered.
- `ram_data_i`  in  `RegBus`  adapter read data.
- `ram_ready_i`  in  1  adapter done.
- `stallreq_o`  out  1  combinational: (`mem_ce_i` & ~`mem_ready_o`) | (`if_ce_i` & ~`if_ready_o`).
- `timeout_o`  out  1  one-cycle pulse when a grant is aborted by the timeout.

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, RELEASE.
- IDLE:
  - If `mem_ce_i`=1, go to BUSY_MEM. The data port has fixed priority.
  - Otherwise, if `if_ce_i`=1, go to BUSY_IF.
  - On either grant: latch the port's request into the `ram_*_o` registers, set `ram_ce_o`=1, and clear the timeout counter.
  - For a fetch grant: `ram_we_o`=0 and `ram_sel_o`=4'b1111.
- BUSY_x, adapter answers (`ram_ready_i`=1):
  - Capture `ram_data_i` into `x_data_o`, pulse `x_ready_o`, set `ram_ce_o`=0, go to RELEASE.
  - A write returns `ZeroWord`.
- BUSY_x, requester abort (its ce falls before ready):
  - `ram_ce_o`=0, go to RELEASE.
  - No ready pulse.
- BUSY_x, timeout (counter reaches `TIMEOUT_CYCLES`-1 without ready):
  - `ram_ce_o`=0, `x_data_o`=`ZeroWord`, pulse `x_ready_o` and `timeout_o`, go to RELEASE.
  - The pulse ensures the pipeline never hangs.
- If ready, abort and timeout occur together, ready wins.
- RELEASE:
  - Exactly one cycle with `ram_ce_o`=0, then go to IDLE.
  - The adapter only returns to its idle step when it sees ce low. Its ready may still read 1 during RELEASE; it is ignored.
  - Requests are not sampled in RELEASE.
- Request lines other than ce are ignored after the grant; the latched copies drive the adapter.
- Reset (asynchronous, any state, including mid-transaction):
  - State returns to IDLE; the counter clears.
  - All outputs go to 0 / `ZeroWord`, so the adapter is deasserted immediately.

## Timing
- Edge E0: request seen in IDLE → `ram_ce_o`=1 after E0.
- Edge Er: `ram_ready_i` seen → `x_ready_o`=1 for the cycle after Er.
- Edge Er+1: RELEASE → IDLE.
- Edge Er+2: earliest next grant.
- Arbiter overhead per access: 1 grant cycle + 1 release cycle, added to the adapter latency.
- A back-to-back fetch after a MEM access is granted 2 cycles after `mem_ready_o`.
- Counter width is 8 bits; it saturates, never wraps.

## Structure
- Add to `defines.v`:
  - state encodings `ArbIdle`/`ArbBusyIf`/`ArbBusyMem`/`ArbRelease` (2 bits);
  - `ArbGrantIf`/`ArbGrantMem`.
- Reuse the existing `RegBus`, `ZeroWord`, `ChipEnable`/`ChipDisable` and `RstEnable` defines.
- Single module, no sub-module. The top level instantiates `ram_arbiter` in front of `ram_adapter`.

## Test plan
- **Fetch read:** `if_ce_i`=1, `if_addr_i`=0x0000_0010; adapter model answers 0x2402_0005 after 2 cycles → `if_ready_o` pulses once with that data; `ram_ce_o` is low for exactly one cycle after; `stallreq_o` falls with the pulse.
- **Contention:** `mem_ce_i` and `if_ce_i` rise in the same cycle; MEM is a write, sel=4'b0011, addr 0x0000_0100, data 0x0000_BEEF → MEM is served first (`ram_we_o`=1, `ram_sel_o`=0011, `mem_data_o`=0); the fetch is granted 2 cycles after `mem_ready_o`.
- **Abort:** `if_ce_i` falls in cycle 1 of BUSY_IF → no `if_ready_o`, `ram_ce_o`=0 next cycle, back to IDLE after RELEASE.
- **Timeout:** `TIMEOUT_CYCLES`=4, adapter never readies → after 4 BUSY cycles `timeout_o` and `mem_ready_o` pulse together with `mem_data_o`=0.
- **Reset mid-transaction:** `rst` asserted between clock edges during BUSY_MEM → `ram_ce_o` and `mem_ready_o` go to 0 without waiting for an edge; the first request after reset is granted normally.
- **Ready vs abort:** ready and ce-fall in the same cycle → ready pulse is produced, with the returned data.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Bus width, zero word, chip-enable levels and the FSM encoding live here.
package ram_arbiter_pkg;

    localparam int REG_W = 32;
    localparam logic [REG_W-1:0] ZERO_WORD = '0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic [3:0] SEL_ALL = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_BUSY_IF  = 2'b01,
        ARB_BUSY_MEM = 2'b10,
        ARB_RELEASE  = 2'b11
    } arb_state_e;

    typedef enum logic {
        ARB_GRANT_IF  = 1'b0,
        ARB_GRANT_MEM = 1'b1
    } arb_grant_e;

    // Latched copy of the winning request, driven onto the adapter.
    typedef struct packed {
        logic             we;
        logic [3:0]       sel;
        logic [REG_W-1:0] addr;
        logic [REG_W-1:0] data;
    } ram_req_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares one ram_adapter between the fetch port and the data port.
// One request at a time, data port first, a release cycle between grants.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_ce_i,
    input  logic [REG_W-1:0] if_addr_i,
    output logic [REG_W-1:0] if_data_o,
    output logic             if_ready_o,
    input  logic             mem_ce_i,
    input  logic             mem_we_i,
    input  logic [3:0]       mem_sel_i,
    input  logic [REG_W-1:0] mem_addr_i,
    input  logic [REG_W-1:0] mem_data_i,
    output logic [REG_W-1:0] mem_data_o,
    output logic             mem_ready_o,
    output logic             ram_ce_o,
    output logic             ram_we_o,
    output logic [3:0]       ram_sel_o,
    output logic [REG_W-1:0] ram_addr_o,
    output logic [REG_W-1:0] ram_data_o,
    input  logic [REG_W-1:0] ram_data_i,
    input  logic             ram_ready_i,
    output logic             stallreq_o,
    output logic             timeout_o
);

    arb_state_e state, state_nxt;
    arb_grant_e port;
    ram_req_t   req, req_nxt;
    logic [7:0] cnt;
    logic       ce_nxt, if_rdy_nxt, mem_rdy_nxt, to_nxt;
    logic [REG_W-1:0] if_data_nxt, mem_data_nxt;
    logic       busy, cur_ce, expired;

    assign busy    = (state == ARB_BUSY_IF) || (state == ARB_BUSY_MEM);
    assign port    = (state == ARB_BUSY_MEM) ? ARB_GRANT_MEM : ARB_GRANT_IF;
    assign cur_ce  = (port == ARB_GRANT_MEM) ? mem_ce_i : if_ce_i;
    assign expired = (cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (mem_ce_i)     state_nxt = ARB_BUSY_MEM;
                else if (if_ce_i) state_nxt = ARB_BUSY_IF;
            end
            ARB_BUSY_IF, ARB_BUSY_MEM: begin
                if (ram_ready_i || !cur_ce || expired) state_nxt = ARB_RELEASE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Next values of the registered outputs; ready beats abort beats timeout.
    always_comb begin
        req_nxt      = req;
        ce_nxt       = ram_ce_o;
        if_rdy_nxt   = 1'b0;
        mem_rdy_nxt  = 1'b0;
        to_nxt       = 1'b0;
        if_data_nxt  = ZERO_WORD;
        mem_data_nxt = ZERO_WORD;
        case (state)
            ARB_IDLE: begin
                if (mem_ce_i) begin
                    req_nxt = '{we: mem_we_i, sel: mem_sel_i, addr: mem_addr_i, data: mem_data_i};
                    ce_nxt  = CHIP_ENABLE;
                end else if (if_ce_i) begin
                    req_nxt = '{we: 1'b0, sel: SEL_ALL, addr: if_addr_i, data: ZERO_WORD};
                    ce_nxt  = CHIP_ENABLE;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_MEM: begin
                if (ram_ready_i) begin
                    ce_nxt = CHIP_DISABLE;
                    if (port == ARB_GRANT_MEM) begin
                        mem_rdy_nxt  = 1'b1;
                        mem_data_nxt = req.we ? ZERO_WORD : ram_data_i;
                    end else begin
                        if_rdy_nxt  = 1'b1;
                        if_data_nxt = ram_data_i;
                    end
                end else if (!cur_ce) begin
                    ce_nxt = CHIP_DISABLE;
                end else if (expired) begin
                    ce_nxt = CHIP_DISABLE;
                    to_nxt = 1'b1;
                    if (port == ARB_GRANT_MEM) mem_rdy_nxt = 1'b1;
                    else                       if_rdy_nxt  = 1'b1;
                end
            end
            default: ce_nxt = CHIP_DISABLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req         <= '0;
            ram_ce_o    <= CHIP_DISABLE;
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            timeout_o   <= 1'b0;
            if_data_o   <= ZERO_WORD;
            mem_data_o  <= ZERO_WORD;
        end else begin
            req         <= req_nxt;
            ram_ce_o    <= ce_nxt;
            if_ready_o  <= if_rdy_nxt;
            mem_ready_o <= mem_rdy_nxt;
            timeout_o   <= to_nxt;
            if_data_o   <= if_data_nxt;
            mem_data_o  <= mem_data_nxt;
        end
    end

    // Grant-age counter; saturates so a long wait can never alias back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       cnt <= 8'd0;
        else if (state == ARB_IDLE)    cnt <= 8'd0;
        else if (busy && cnt != 8'hFF) cnt <= cnt + 8'd1;
    end

    assign ram_we_o   = req.we;
    assign ram_sel_o  = req.sel;
    assign ram_addr_o = req.addr;
    assign ram_data_o = req.data;

    assign stallreq_o = (mem_ce_i & ~mem_ready_o) | (if_ce_i & ~if_ready_o);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations, then
// random requesters and adapter, checked every cycle against a transaction model.
module tb_ram_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_ce_i = 1'b0, mem_ce_i = 1'b0, mem_we_i = 1'b0, ram_ready_i = 1'b0;
    logic [3:0]  mem_sel_i = 4'h0;
    logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_data_i = '0, ram_data_i = '0;
    logic [31:0] if_data_o, mem_data_o, ram_addr_o, ram_data_o;
    logic        if_ready_o, mem_ready_o, ram_ce_o, ram_we_o, stallreq_o, timeout_o;
    logic [3:0]  ram_sel_o;

    always #5 clk = ~clk;

    ram_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_ready_o(mem_ready_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o), .ram_addr_o(ram_addr_o),
        .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .ram_ready_i(ram_ready_i),
        .stallreq_o(stallreq_o), .timeout_o(timeout_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the adapter, how long it has waited,
    // and whether the mandatory idle cycle is pending.
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    int          m_age = 0;
    bit          m_cool = 1'b0;
    logic        e_ce = 0, e_we = 0, e_if_rdy = 0, e_mem_rdy = 0, e_to = 0;
    logic [3:0]  e_sel = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_if_data = 0, e_mem_data = 0;

    task automatic model_reset();
        m_owner = 0; m_age = 0; m_cool = 1'b0;
        e_ce = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
        e_if_rdy = 0; e_mem_rdy = 0; e_to = 0; e_if_data = 0; e_mem_data = 0;
    endtask

    task automatic deliver(input logic [31:0] d, input logic to);
        if (m_owner == 2) begin e_mem_rdy = 1; e_mem_data = d; end
        else begin e_if_rdy = 1; e_if_data = d; end
        e_to = to;
    endtask

    task automatic model_step();
        logic still;
        bit   done;
        e_if_rdy = 0; e_mem_rdy = 0; e_to = 0; e_if_data = 0; e_mem_data = 0;
        if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_owner == 0) begin
            if (mem_ce_i) begin
                m_owner = 2; m_age = 0; e_ce = 1;
                e_we = mem_we_i; e_sel = mem_sel_i; e_addr = mem_addr_i; e_wdata = mem_data_i;
            end else if (if_ce_i) begin
                m_owner = 1; m_age = 0; e_ce = 1;
                e_we = 0; e_sel = 4'hF; e_addr = if_addr_i; e_wdata = 0;
            end
        end else begin
            done  = 1'b0;
            still = (m_owner == 2) ? mem_ce_i : if_ce_i;
            if (ram_ready_i) begin
                done = 1'b1;
                deliver((m_owner == 2 && e_we) ? 32'h0 : ram_data_i, 1'b0);
            end else if (!still) begin
                done = 1'b1;
            end else if (m_age == T - 1) begin
                done = 1'b1;
                deliver(32'h0, 1'b1);
            end else begin
                m_age++;
            end
            if (done) begin m_owner = 0; m_cool = 1'b1; e_ce = 0; end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else begin
                model_step();
                #1;
                if (!rst) begin
                    chk1("ram_ce", ram_ce_o, e_ce);
                    chk1("ram_we", ram_we_o, e_we);
                    chk32("ram_sel", {28'h0, ram_sel_o}, {28'h0, e_sel});
                    chk32("ram_addr", ram_addr_o, e_addr);
                    chk32("ram_wdata", ram_data_o, e_wdata);
                    chk1("if_ready", if_ready_o, e_if_rdy);
                    chk1("mem_ready", mem_ready_o, e_mem_rdy);
                    chk1("timeout", timeout_o, e_to);
                    if (e_if_rdy) chk32("if_data", if_data_o, e_if_data);
                    if (e_mem_rdy) chk32("mem_data", mem_data_o, e_mem_data);
                    chk1("stallreq", stallreq_o, (mem_ce_i & ~e_mem_rdy) | (if_ce_i & ~e_if_rdy));
                end
            end
        end
    end

    task automatic step(); @(negedge clk); endtask

    initial begin
        step(); step();
        chk1("rst_ram_ce", ram_ce_o, 1'b0);
        chk1("rst_if_ready", if_ready_o, 1'b0);
        chk1("rst_mem_ready", mem_ready_o, 1'b0);
        chk32("rst_ram_addr", ram_addr_o, 32'h0);
        chk1("rst_stall", stallreq_o, 1'b0);
        rst = 1'b0;
        step();

        // Fetch read, adapter answers on the second busy cycle
        if_ce_i = 1; if_addr_i = 32'h0000_0010;
        step();
        chk1("fetch_ce", ram_ce_o, 1'b1);
        chk32("fetch_addr", ram_addr_o, 32'h0000_0010);
        chk32("fetch_sel", {28'h0, ram_sel_o}, 32'hF);
        chk1("fetch_we", ram_we_o, 1'b0);
        chk1("fetch_stall", stallreq_o, 1'b1);
        step();
        ram_ready_i = 1; ram_data_i = 32'h2402_0005;
        step();
        chk1("fetch_ready", if_ready_o, 1'b1);
        chk32("fetch_data", if_data_o, 32'h2402_0005);
        chk1("fetch_ce_low", ram_ce_o, 1'b0);
        chk1("fetch_stall_low", stallreq_o, 1'b0);
        if_ce_i = 0; ram_ready_i = 0;
        step();
        chk1("fetch_single_pulse", if_ready_o, 1'b0);
        step();

        // Contention: data write wins, fetch granted two cycles after mem_ready
        mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b0011;
        mem_addr_i = 32'h0000_0100; mem_data_i = 32'h0000_BEEF;
        if_ce_i = 1; if_addr_i = 32'h0000_0020;
        step();
        chk1("cont_we", ram_we_o, 1'b1);
        chk32("cont_sel", {28'h0, ram_sel_o}, 32'h3);
        chk32("cont_addr", ram_addr_o, 32'h0000_0100);
        chk32("cont_wdata", ram_data_o, 32'h0000_BEEF);
        ram_ready_i = 1; ram_data_i = 32'hDEAD_0000;
        step();
        chk1("cont_mem_ready", mem_ready_o, 1'b1);
        chk32("cont_mem_data", mem_data_o, 32'h0);
        chk1("cont_if_wait", if_ready_o, 1'b0);
        mem_ce_i = 0; mem_we_i = 0; ram_ready_i = 0;
        step();
        chk1("cont_release", ram_ce_o, 1'b0);
        step();
        chk1("cont_if_grant", ram_ce_o, 1'b1);
        chk32("cont_if_addr", ram_addr_o, 32'h0000_0020);
        ram_ready_i = 1; ram_data_i = 32'h1234_5678;
        step();
        chk32("cont_if_data", if_data_o, 32'h1234_5678);
        if_ce_i = 0; ram_ready_i = 0;
        step(); step();

        // Abort: fetch withdrawn in its first busy cycle
        if_ce_i = 1; if_addr_i = 32'h0000_0044;
        step();
        if_ce_i = 0;
        step();
        chk1("abort_ce", ram_ce_o, 1'b0);
        chk1("abort_no_ready", if_ready_o, 1'b0);
        step(); step();
        chk1("abort_idle", ram_ce_o, 1'b0);

        // Timeout: data read, adapter silent
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h0000_0200;
        step();
        for (int i = 0; i < T - 1; i++) begin
            step();
            chk1("to_not_yet", timeout_o, 1'b0);
            chk1("to_ce_held", ram_ce_o, 1'b1);
        end
        step();
        chk1("to_pulse", timeout_o, 1'b1);
        chk1("to_mem_ready", mem_ready_o, 1'b1);
        chk32("to_mem_data", mem_data_o, 32'h0);
        chk1("to_ce_low", ram_ce_o, 1'b0);
        mem_ce_i = 0;
        step(); step();

        // Reset between edges while the data port is busy
        mem_ce_i = 1; mem_addr_i = 32'h0000_0300;
        step();
        chk1("rmid_granted", ram_ce_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("rmid_ce", ram_ce_o, 1'b0);
        chk1("rmid_ready", mem_ready_o, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk1("rmid_regrant", ram_ce_o, 1'b1);
        chk32("rmid_addr", ram_addr_o, 32'h0000_0300);
        ram_ready_i = 1; ram_data_i = 32'h1111_2222;
        step();
        chk32("rmid_data", mem_data_o, 32'h1111_2222);
        mem_ce_i = 0; ram_ready_i = 0;
        step(); step();

        // Ready and abort together: ready wins
        if_ce_i = 1; if_addr_i = 32'h0000_0050;
        step();
        if_ce_i = 0; ram_ready_i = 1; ram_data_i = 32'hCAFE_0001;
        step();
        chk1("rva_ready", if_ready_o, 1'b1);
        chk32("rva_data", if_data_o, 32'hCAFE_0001);
        ram_ready_i = 0;
        step(); step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (mem_ce_i && !mem_ready_o) begin
                if ($urandom_range(0, 19) == 0) mem_ce_i = 0;
                if ($urandom_range(0, 2) == 0) begin mem_addr_i = $urandom; mem_data_i = $urandom; end
            end else begin
                mem_ce_i = ($urandom_range(0, 2) == 0);
                mem_we_i = $urandom_range(0, 1);
                mem_sel_i = 4'($urandom_range(0, 15));
                mem_addr_i = $urandom; mem_data_i = $urandom;
            end
            if (if_ce_i && !if_ready_o) begin
                if ($urandom_range(0, 19) == 0) if_ce_i = 0;
                if ($urandom_range(0, 2) == 0) if_addr_i = $urandom;
            end else begin
                if_ce_i = ($urandom_range(0, 2) != 0);
                if_addr_i = $urandom;
            end
            ram_ready_i = ($urandom_range(0, 3) == 0);
            ram_data_i = $urandom;
            step();
        end
        mem_ce_i = 0; if_ce_i = 0; ram_ready_i = 0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
